// File: rtl/slvds_rx_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : slvds_rx_multi_if
// Purpose  : Bundle of serial lanes, per-lane status pulses and counters
//            exchanged between the LVDS source and the multi-lane receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface slvds_rx_multi_if #(
    parameter int NCH    = 4,
    parameter int DATA_W = 16,
    parameter int TAIL_W = 2,
    parameter int CNT_W  = 16
);
    logic [NCH-1:0]        in;
    logic [NCH-1:0]        locked;
    logic [NCH-1:0]        dv;
    logic [NCH*DATA_W-1:0] out;
    logic [NCH*TAIL_W-1:0] tail;
    logic [NCH-1:0]        glitch;
    logic [NCH-1:0]        perr;
    logic [CNT_W-1:0]      frame_cnt;
    logic [CNT_W-1:0]      err_cnt;

    modport master (
        output in,
        input  locked, dv, out, tail, glitch, perr, frame_cnt, err_cnt
    );

    modport slave (
        input  in,
        output locked, dv, out, tail, glitch, perr, frame_cnt, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/slvds_rx_multi.sv
`default_nettype none
// ============================================================================
// Module   : slvds_rx_multi
// Purpose  : NCH-lane serial-LVDS frame receiver with idle lock, glitch relock
//            and saturating frame/error counters. Optional SLVDS_RX_PARITY_EN
//            enables even-parity checking of the payload against tail[0].
// Revision : 1.0 - initial release
// ============================================================================
module slvds_rx_multi #(
    parameter int NCH      = 4,
    parameter int DATA_W   = 16,
    parameter int TAIL_W   = 2,
    parameter int SYNC_LEN = 20,
    parameter int CNT_W    = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    slvds_rx_multi_if.slave bus
);
    localparam int c_FW = DATA_W + TAIL_W;
    localparam int c_ZW = $clog2(SYNC_LEN + 1);
    localparam int c_BW = (c_FW > 1) ? $clog2(c_FW) : 1;
    localparam logic [c_ZW-1:0] c_ZLAST = c_ZW'(SYNC_LEN - 1);
    localparam logic [c_BW-1:0] c_BLAST = c_BW'(c_FW - 1);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_IDLE = 2'd1,
        S_ARM  = 2'd2,
        S_RECV = 2'd3
    } state_t;

    logic [NCH-1:0]        w_locked;
    logic [NCH-1:0]        w_dv;
    logic [NCH-1:0]        w_glitch;
    logic [NCH-1:0]        w_perr;
    logic [NCH*DATA_W-1:0] w_out;
    logic [NCH*TAIL_W-1:0] w_tail;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        state_t            r_state, w_state_nxt;
        logic [c_ZW-1:0]   r_zcnt, w_zcnt_nxt;
        logic [c_BW-1:0]   r_bcnt, w_bcnt_nxt;
        logic [c_FW-1:0]   r_sreg;
        logic [c_FW-1:0]   w_word;
        logic [DATA_W-1:0] r_out;
        logic [TAIL_W-1:0] r_tail;
        logic              r_dv, r_glitch, r_perr;
        logic              w_bit, w_done, w_bad, w_glitch_ev;

        assign w_bit  = bus.in[c];
        // Bits arrive LSB first, so the newest bit enters at the top.
        assign w_word = {w_bit, r_sreg[c_FW-1:1]};

`ifdef SLVDS_RX_PARITY_EN
        assign w_bad = w_word[DATA_W] != (^w_word[DATA_W-1:0]);
`else
        assign w_bad = 1'b0;
`endif

        always_comb begin
            w_state_nxt = r_state;
            w_zcnt_nxt  = r_zcnt;
            w_bcnt_nxt  = r_bcnt;
            w_done      = 1'b0;
            w_glitch_ev = 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (w_bit) begin
                        w_zcnt_nxt = '0;
                    end else if (r_zcnt == c_ZLAST) begin
                        w_state_nxt = S_IDLE;
                        w_zcnt_nxt  = '0;
                    end else begin
                        w_zcnt_nxt = r_zcnt + c_ZW'(1);
                    end
                end
                S_IDLE: begin
                    if (w_bit) w_state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (w_bit) begin
                        w_state_nxt = S_RECV;
                        w_bcnt_nxt  = '0;
                    end else begin
                        // The offending zero already counts toward relock.
                        w_glitch_ev = 1'b1;
                        w_state_nxt = S_HUNT;
                        w_zcnt_nxt  = c_ZW'(1);
                    end
                end
                S_RECV: begin
                    w_bcnt_nxt = r_bcnt + c_BW'(1);
                    if (r_bcnt == c_BLAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= S_HUNT;
                r_zcnt   <= '0;
                r_bcnt   <= '0;
                r_sreg   <= '0;
                r_out    <= '0;
                r_tail   <= '0;
                r_dv     <= 1'b0;
                r_glitch <= 1'b0;
                r_perr   <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_zcnt   <= w_zcnt_nxt;
                r_bcnt   <= w_bcnt_nxt;
                r_dv     <= w_done & ~w_bad;
                r_perr   <= w_done & w_bad;
                r_glitch <= w_glitch_ev;
                if (r_state == S_RECV) r_sreg <= w_word;
                if (w_done && !w_bad) begin
                    r_out  <= w_word[DATA_W-1:0];
                    r_tail <= w_word[c_FW-1:DATA_W];
                end
            end
        end

        assign w_locked[c]                   = (r_state != S_HUNT);
        assign w_dv[c]                       = r_dv;
        assign w_glitch[c]                   = r_glitch;
        assign w_perr[c]                     = r_perr;
        assign w_out[c*DATA_W +: DATA_W]     = r_out;
        assign w_tail[c*TAIL_W +: TAIL_W]    = r_tail;
    end

    function automatic logic [CNT_W:0] f_popcount(input logic [NCH-1:0] v);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) n = n + {{CNT_W{1'b0}}, v[i]};
        return n;
    endfunction

    logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;
    logic [CNT_W:0]   w_frame_sum, w_err_sum;

    assign w_frame_sum = {1'b0, r_frame_cnt} + f_popcount(w_dv);
    assign w_err_sum   = {1'b0, r_err_cnt} + f_popcount(w_glitch | w_perr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_cnt <= w_frame_sum[CNT_W] ? '1 : w_frame_sum[CNT_W-1:0];
            r_err_cnt   <= w_err_sum[CNT_W]   ? '1 : w_err_sum[CNT_W-1:0];
        end
    end

    assign bus.locked    = w_locked;
    assign bus.dv        = w_dv;
    assign bus.glitch    = w_glitch;
    assign bus.perr      = w_perr;
    assign bus.out       = w_out;
    assign bus.tail      = w_tail;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;
endmodule
`default_nettype wire
